// File: rtl/median_sort_pipe.sv
// median_sort_pipe: pipelined odd-even transposition sorter with median tap.
// One N-lane vector per handshake, N compare-exchange stages, a register slot
// after every REG_EVERY stages (and after the last), global stall on back-pressure.
// Optional build macro MEDIAN_SORT_PIPE_STATS_EN adds stat_accepted / stat_stall.
module median_sort_pipe #(
    parameter int N         = 13,
    parameter int W         = 32,
    parameter int REG_EVERY = 2,
    parameter int SIGNED    = 0,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*W-1:0]     out_sort,
    output logic [W-1:0]       out_median,
    output logic [TAG_W-1:0]   out_tag
`ifdef MEDIAN_SORT_PIPE_STATS_EN
    ,
    output logic [31:0]        stat_accepted,
    output logic [31:0]        stat_stall
`endif
);

    localparam int L = (N + REG_EVERY - 1) / REG_EVERY;

    typedef logic [N-1:0][W-1:0] vec_t;

    if (N < 3 || N > 31 || (N % 2) == 0) begin : g_bad_n
        $error("median_sort_pipe: N must be odd and in 3..31");
    end
    if (REG_EVERY < 1 || REG_EVERY > N) begin : g_bad_reg
        $error("median_sort_pipe: REG_EVERY must be in 1..N");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("median_sort_pipe: TAG_W must be >= 1");
    end

    // a > b under the configured signedness; equal lanes never swap (stable)
    function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    logic             adv;
    vec_t             slot_d  [L];
    vec_t             slot_in [L];
    logic [L:1]       vld_q;
    logic [L:0]       vld_pipe;
    logic [L:1][TAG_W-1:0] tag_q;
    logic [L:0][TAG_W-1:0] tag_pipe;

    // Single global stall: everything moves together or nothing moves
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Index 0 is the incoming handshake; index k is the register after slot k-1
    assign vld_pipe = {vld_q, in_valid};
    assign tag_pipe = {tag_q, in_tag};

    for (genvar s = 0; s < N; s++) begin : g_stage
        vec_t a;
        vec_t o;
        if (s == 0) begin : g_src
            assign a = in_data;
        end else if ((s % REG_EVERY) == 0) begin : g_src
            assign a = slot_d[s/REG_EVERY - 1];
        end else begin : g_src
            assign a = g_stage[s-1].o;
        end

        // One transposition stage: even pairs on even s, odd pairs on odd s
        always_comb begin
            o = a;
            for (int i = s % 2; i + 1 < N; i += 2) begin
                if (gt(a[i], a[i+1])) begin
                    o[i]   = a[i+1];
                    o[i+1] = a[i];
                end
            end
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_slot
        localparam int LAST = (((k + 1) * REG_EVERY < N) ? (k + 1) * REG_EVERY : N) - 1;
        assign slot_in[k] = g_stage[LAST].o;
    end

    // Slot registers: flush beats advance for valids; data/tags only move on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
            for (int k = 0; k < L; k++) slot_d[k] <= '0;
        end else begin
            if (flush)    vld_q <= '0;
            else if (adv) vld_q <= vld_pipe[L-1:0];
            if (adv) begin
                tag_q <= tag_pipe[L-1:0];
                for (int k = 0; k < L; k++) slot_d[k] <= slot_in[k];
            end
        end
    end

    assign out_valid  = vld_pipe[L];
    assign out_tag    = tag_pipe[L];
    assign out_sort   = slot_d[L-1];
    assign out_median = slot_d[L-1][(N-1)/2];

`ifdef MEDIAN_SORT_PIPE_STATS_EN
    // Free-running wrap counters, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepted <= '0;
            stat_stall    <= '0;
        end else begin
            if (in_valid && adv)          stat_accepted <= stat_accepted + 32'd1;
            if (out_valid && !out_ready)  stat_stall    <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_median_sort_pipe.sv
// Bench for median_sort_pipe: N=5 W=8 REG_EVERY=2 (L=3), one unsigned and one
// signed instance sharing stimulus, scored against a plain integer sort model.
module tb_median_sort_pipe;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int R  = 2;
    localparam int TW = 4;
    localparam int L  = 3;
    localparam int MID = (N - 1) / 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [TW-1:0]  in_tag = '0;

    logic           in_ready, out_valid, in_ready_s, out_valid_s;
    logic [N*W-1:0] out_sort, out_sort_s;
    logic [W-1:0]   out_median, out_median_s;
    logic [TW-1:0]  out_tag, out_tag_s;
`ifdef MEDIAN_SORT_PIPE_STATS_EN
    logic [31:0]    stat_accepted, stat_stall, stat_accepted_s, stat_stall_s;
`endif

    median_sort_pipe #(.N(N), .W(W), .REG_EVERY(R), .SIGNED(0), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sort(out_sort),
        .out_median(out_median), .out_tag(out_tag)
`ifdef MEDIAN_SORT_PIPE_STATS_EN
        , .stat_accepted(stat_accepted), .stat_stall(stat_stall)
`endif
    );

    median_sort_pipe #(.N(N), .W(W), .REG_EVERY(R), .SIGNED(1), .TAG_W(TW)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_sort(out_sort_s),
        .out_median(out_median_s), .out_tag(out_tag_s)
`ifdef MEDIAN_SORT_PIPE_STATS_EN
        , .stat_accepted(stat_accepted_s), .stat_stall(stat_stall_s)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: lanes as integers, ordinary bubble sort, repacked
    function automatic logic [N*W-1:0] ref_sort(input logic [N*W-1:0] v, input bit sgn);
        int a [N];
        int t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++)
            a[i] = sgn ? int'($signed(v[i*W +: W])) : int'(v[i*W +: W]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // Scoreboard
    logic [N*W-1:0] exp_u [$];
    logic [N*W-1:0] exp_s [$];
    logic [TW-1:0]  exp_t [$];
    logic [N*W-1:0] e_u, e_s, hold_sort;
    logic [TW-1:0]  hold_tag;
    bit             hold_vld = 0;
    int             outs = 0;
    int             acc_cnt = 0;

    // Monitor on the falling edge: output checks, stability, then record accepts
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_u.delete(); exp_s.delete(); exp_t.delete();
            hold_vld = 0;
            acc_cnt  = 0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (hold_vld) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sort", out_sort, hold_sort);
                chk("hold_tag", out_tag, hold_tag);
            end
            if (out_valid) begin
                if (exp_u.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e_u = exp_u[0];
                    e_s = exp_s[0];
                    chk("sort", out_sort, e_u);
                    chk("median", out_median, e_u[MID*W +: W]);
                    chk("tag", out_tag, exp_t[0]);
                    chk("valid_s", out_valid_s, 1);
                    chk("sort_s", out_sort_s, e_s);
                    chk("median_s", out_median_s, e_s[MID*W +: W]);
                    if (out_ready) begin
                        void'(exp_u.pop_front());
                        void'(exp_s.pop_front());
                        void'(exp_t.pop_front());
                        outs++;
                    end
                end
            end
            hold_vld  = out_valid && !out_ready && !flush;
            hold_sort = out_sort;
            hold_tag  = out_tag;
            if (in_valid && in_ready) acc_cnt++;
            if (flush) begin
                exp_u.delete(); exp_s.delete(); exp_t.delete();
            end else if (in_valid && in_ready) begin
                exp_u.push_back(ref_sort(in_data, 0));
                exp_s.push_back(ref_sort(in_data, 1));
                exp_t.push_back(in_tag);
            end
        end
    end

    // Send one vector into an empty pipe and measure accept->out_valid cycles
    task automatic send1(input logic [N*W-1:0] d, input logic [TW-1:0] t, output int lat);
        in_valid = 1'b1; in_data = d; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        chk("drain_empty", exp_u.size(), 0);
    endtask

    int lat;
    int o0;
    logic [31:0] st0;

    initial begin
        // Reset state
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_sort", out_sort, 0);
        chk("rst_median", out_median, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef MEDIAN_SORT_PIPE_STATS_EN
        chk("rst_stat_acc", stat_accepted, 0);
        chk("rst_stat_stall", stat_stall, 0);
`endif
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single vector latency, values, one-cycle pulse
        send1({8'd5, 8'd1, 8'd7, 8'd3, 8'd9}, 4'd2, lat);
        chk("t1_latency", lat, L);
        chk("t1_sort", out_sort, {8'd9, 8'd7, 8'd5, 8'd3, 8'd1});
        chk("t1_median", out_median, 8'd5);
        chk("t1_tag", out_tag, 4'd2);
        @(posedge clk); #1;
        chk("t1_pulse", out_valid, 0);
        drain(2);

        // 4: signed ordering on the signed instance
        send1({8'h01, 8'hFF, 8'h00, 8'h7F, 8'h80}, 4'd4, lat);
        chk("t4_latency", lat, L);
        chk("t4_sort_s", out_sort_s, {8'h7F, 8'h01, 8'h00, 8'hFF, 8'h80});
        chk("t4_median_s", out_median_s, 8'h00);
        drain(2);

        // 2: back-to-back 20 random vectors plus a duplicate-heavy one
        o0 = outs;
        for (int k = 0; k < 21; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 10) ? {8'd2, 8'd2, 8'd4, 8'd4, 8'd4} : rand_vec();
            in_tag   = TW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        chk("t2_throughput", outs - o0, 21);
        drain(3);

        // 3: stall 5 cycles with the pipe full
        for (int k = 0; k < L; k++) begin
            in_valid = 1'b1; in_data = rand_vec(); in_tag = TW'($urandom);
            @(posedge clk); #1;
        end
`ifdef MEDIAN_SORT_PIPE_STATS_EN
        st0 = stat_stall;
`endif
        out_ready = 1'b0;
        repeat (5) begin
            in_data = rand_vec();
            @(posedge clk); #1;
            chk("t3_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
`ifdef MEDIAN_SORT_PIPE_STATS_EN
        chk("t3_stat_stall", stat_stall - st0, 5);
`endif
        for (int k = 0; k < 3; k++) begin
            in_data = rand_vec(); in_tag = TW'($urandom);
            @(posedge clk); #1;
        end
        drain(L + 2);

        // 5: flush with three vectors in flight, accept during flush discarded
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = rand_vec(); in_tag = TW'($urandom);
            @(posedge clk); #1;
        end
        flush = 1'b1; in_data = rand_vec();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flush_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("t5_flush_valid2", out_valid, 0);
        send1(rand_vec(), 4'd9, lat);
        chk("t5_latency", lat, L);
        chk("t5_tag", out_tag, 4'd9);
        drain(2);

        // Random valid / ready traffic
        for (int k = 0; k < 80; k++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = rand_vec();
            in_tag    = TW'($urandom);
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        drain(L + 3);

        // 6: async reset mid-stream
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = rand_vec(); in_tag = TW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_sort", out_sort, 0);
        chk("t6_median", out_median, 0);
        chk("t6_tag", out_tag, 0);
        chk("t6_in_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_partial", out_valid, 0);
        send1({8'd5, 8'd1, 8'd7, 8'd3, 8'd9}, 4'd6, lat);
        chk("t6_latency", lat, L);
        chk("t6_sort", out_sort, {8'd9, 8'd7, 8'd5, 8'd3, 8'd1});
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = rand_vec(); in_tag = TW'($urandom);
            @(posedge clk); #1;
        end
        drain(L + 2);
`ifdef MEDIAN_SORT_PIPE_STATS_EN
        chk("stat_accepted", stat_accepted, acc_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
